// File: rtl/axi_rd_arbiter.sv
// Arbitrates the core's single AXI4 read channel between instruction fetch and data load.
// Optional `INST_BUF_EN adds a one-entry fetch result buffer so an unready if_id stage cannot hold the bus.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter logic [3:0]  INST_ID = 4'h0,
  parameter logic [3:0]  DATA_ID = 4'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_valid,
  output logic              inst_err,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              data_err,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

`ifdef INST_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AR_INST = 3'd1,
    AR_DATA = 3'd2,
    R_INST  = 3'd3,
    R_DATA  = 3'd4,
    DRAIN   = 3'd5
  } state_e;

  state_e              state_q;
  logic                flush_pend_q;
  logic                arvalid_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [3:0]          arid_q;
  logic [DATA_W-1:0]   inst_rdata_q;
  logic                inst_valid_q;
  logic                inst_err_q;
  logic [DATA_W-1:0]   data_rdata_q;
  logic                data_valid_q;
  logic                data_err_q;
  logic                rready_c;
  logic                inst_buf_busy;

  // Single-beat single-ID transactions: rid and rlast carry no information here.
  logic unused_rsp;
  assign unused_rsp = ^{rid, rlast};

  // A held fetch result blocks new fetches until if_id takes it.
  assign inst_buf_busy = BUF_EN && inst_valid_q && !inst_ready;

  // R-channel ready: fetch beats follow if_id backpressure unless buffered.
  always_comb begin
    rready_c = 1'b0;
    case (state_q)
      R_DATA, DRAIN: rready_c = 1'b1;
      R_INST:        rready_c = BUF_EN ? 1'b1 : inst_ready;
      default:       rready_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arid_q       <= 4'h0;
      inst_rdata_q <= '0;
      inst_valid_q <= 1'b0;
      inst_err_q   <= 1'b0;
      data_rdata_q <= '0;
      data_valid_q <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (!BUF_EN || flush || (inst_valid_q && inst_ready)) begin
        inst_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (data_req) begin
            araddr_q  <= data_addr;
            arid_q    <= DATA_ID;
            arvalid_q <= 1'b1;
            state_q   <= AR_DATA;
          end else if (inst_req && !flush && !inst_buf_busy) begin
            araddr_q  <= inst_addr;
            arid_q    <= INST_ID;
            arvalid_q <= 1'b1;
            state_q   <= AR_INST;
          end
        end
        // AR is never withdrawn once offered; a flush only redirects the response to DRAIN.
        AR_INST: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (arready) begin
            arvalid_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            state_q      <= (flush || flush_pend_q) ? DRAIN : R_INST;
          end
        end
        AR_DATA: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            state_q   <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid) begin
            data_rdata_q <= rdata;
            data_err_q   <= (rresp != 2'b00);
            data_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        R_INST: begin
          if (rvalid && rready_c) begin
            if (!flush) begin
              inst_rdata_q <= rdata;
              inst_err_q   <= (rresp != 2'b00);
              inst_valid_q <= 1'b1;
            end
            state_q <= IDLE;
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (rvalid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arvalid    = arvalid_q;
  assign araddr     = araddr_q;
  assign arid       = arid_q;
  assign arlen      = 8'd0;
  assign arsize     = 3'b010;
  assign arburst    = 2'b01;
  assign rready     = rready_c;
  assign inst_rdata = inst_rdata_q;
  assign inst_valid = inst_valid_q;
  assign inst_err   = inst_err_q;
  assign data_rdata = data_rdata_q;
  assign data_valid = data_valid_q;
  assign data_err   = data_err_q;

endmodule
